board_scanner: RTL and testbench
================================

BOARD_SCANNER -- requirements
Module: board_scanner

Interface
REQ-001 Parameter WIN_EXP, default 11, is the tile exponent counted as a win (2^11 = 2048).
REQ-002 clk  input  1  single clock, all state updates on the rising edge.
REQ-003 rst_n  input  1  reset, asynchronous and active-low.
REQ-004 start  input  1  single-cycle request to scan the board.
REQ-005 board  input  64  16 tiles of 4 bits, row-major. Tile k occupies board[63-4k -: 4], with tile 0 top-left. A tile value of 0 means empty; n means 2^n.
REQ-006 busy  output  1  high from the cycle after start is accepted until done.
REQ-007 done  output  1  single-cycle pulse when the result outputs update.
REQ-008 tile_valid  output  1  high while one tile is presented during a scan.
REQ-009 tile_idx  output  4  index of the presented tile.
REQ-010 tile_val  output  4  value of the presented tile.
REQ-011 empty_cnt  output  5  number of empty tiles, range 0..16.
REQ-012 max_tile  output  4  largest tile exponent on the board.
REQ-013 win  output  1  max_tile >= WIN_EXP.
REQ-014 game_over  output  1  no empty tile and no equal horizontally or vertically adjacent pair.

Function
REQ-015 The FSM SHALL have three states: IDLE, SCAN, DONE.
REQ-016 IDLE: start=1 SHALL snapshot board into an internal register, clear the accumulators, set idx=0, and move to SCAN.
REQ-017 SCAN: each cycle SHALL process exactly one tile, snap[idx]; idx SHALL increment by 1.
REQ-018 SCAN: idx=15 SHALL transition to DONE on the next edge; the scan takes 16 cycles total.
REQ-019 DONE SHALL load the result registers, pulse done for one cycle, and return to IDLE.
REQ-020 Latency: start sampled at edge 0 -> done=1 in the cycle after edge 17; busy=1 for cycles 1..16.
REQ-021 Per tile: empty_acc SHALL increment if the tile is 0; max_acc SHALL take max(max_acc, tile).
REQ-022 Per tile: pair_acc SHALL be set if tile == right neighbour (col != 3) or tile == lower neighbour (row != 3), comparing non-zero values only.
REQ-023 No wrap-around: col 3 SHALL NOT be compared with col 0 of the next row, and row 3 SHALL have no lower neighbour.
REQ-024 game_over SHALL equal (empty_acc == 0) && !pair_acc.
REQ-025 tile_valid/tile_idx/tile_val SHALL be registered and mirror the tile processed in the same SCAN cycle; tile_valid SHALL be 0 outside SCAN.
REQ-026 start while busy or in DONE SHALL be ignored.
REQ-027 Changes on board after the snapshot SHALL NOT affect the running scan.
REQ-028 Result outputs SHALL hold their values until the next DONE; they SHALL NOT change during a scan.
REQ-029 empty_cnt SHALL be 5 bits wide so that 16 is representable without overflow.

Reset
REQ-030 rst_n=0 SHALL force state IDLE, idx=0, and the snapshot and accumulators to 0, asynchronously.
REQ-031 During reset, every output SHALL be 0, including empty_cnt and max_tile.
REQ-032 Reset mid-scan SHALL abort the scan with no done pulse; result outputs SHALL return to 0.

Structure
REQ-033 A shared package board_pkg SHALL hold TILE_W=4, SIDE=4, N_TILES=16, the default WIN_EXP, and the scanner state encoding.
REQ-034 A single sub-module board_tile_sel SHALL extract a tile from the 64-bit snapshot by index; it is instantiated three times (current, right, below).

Verification
REQ-035 board=64'h0100000000000010, start -> done at cycle 17, empty_cnt=14, max_tile=1, win=0, game_over=0; tile_val=1 at tile_idx 1 and 14.
REQ-036 board=64'h1212212112122121 -> empty_cnt=0, max_tile=2, game_over=1; this also proves the row-end pairs (tile 3/4, 7/8) are not compared.
REQ-037 board=64'h1212212112122122 -> game_over=0, because tile 15 equals tiles 14 and 11 at the last-tile boundary.
REQ-038 board=64'h00000B0000000000 -> max_tile=11, win=1, empty_cnt=15.
REQ-039 start the scenario of REQ-035, change board to all-zero at cycle 5, and pulse start at cycle 6 -> results exactly as REQ-035, a single done pulse, and the second start ignored.
REQ-040 rst_n=0 at cycle 8 of a scan -> busy=0, no done pulse, outputs 0. A later start with board 64'h0 -> empty_cnt=16, max_tile=0, game_over=0.

Source files
------------

// File: rtl/board_pkg.sv
// Shared constants, scanner state encoding and tile helpers for the 4x4 board scanner.
package board_pkg;

  localparam int TILE_W      = 4;
  localparam int SIDE        = 4;
  localparam int N_TILES     = SIDE * SIDE;
  localparam int IDX_W       = 4;
  localparam int BOARD_W     = N_TILES * TILE_W;
  localparam int CNT_W       = 5;
  localparam int WIN_EXP_DEF = 11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } scan_state_t;

  function automatic logic [TILE_W-1:0] tile_max(input logic [TILE_W-1:0] a,
                                                 input logic [TILE_W-1:0] b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/board_tile_sel.sv
// Extracts one tile from the packed board snapshot; tile 0 sits in the top nibble.
module board_tile_sel
  import board_pkg::*;
(
  input  logic [BOARD_W-1:0] snap,
  input  logic [IDX_W-1:0]   idx,
  output logic [TILE_W-1:0]  val
);

  logic [BOARD_W-1:0] shifted;

  assign shifted = snap >> (TILE_W * (N_TILES - 1 - int'(idx)));
  assign val     = shifted[TILE_W-1:0];

endmodule

// File: rtl/board_scanner.sv
// Scans a snapshot of a 4x4 2048 board one tile per cycle and reports
// empty count, largest tile, win and game-over.
module board_scanner
  import board_pkg::*;
#(
  parameter int WIN_EXP = WIN_EXP_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [BOARD_W-1:0]  board,
  output logic                busy,
  output logic                done,
  output logic                tile_valid,
  output logic [IDX_W-1:0]    tile_idx,
  output logic [TILE_W-1:0]   tile_val,
  output logic [CNT_W-1:0]    empty_cnt,
  output logic [TILE_W-1:0]   max_tile,
  output logic                win,
  output logic                game_over
);

  scan_state_t          state, next_state;
  logic [BOARD_W-1:0]   snap;
  logic [IDX_W-1:0]     idx, idx_right, idx_below;
  logic [TILE_W-1:0]    cur, right, below;
  logic [CNT_W-1:0]     empty_acc;
  logic [TILE_W-1:0]    max_acc;
  logic                 pair_acc;
  logic                 pair_hit;
  logic                 snap_en, scan_en, load_en;

  assign idx_right = idx + IDX_W'(1);
  assign idx_below = idx + IDX_W'(SIDE);

  board_tile_sel u_sel_cur   (.snap(snap), .idx(idx),       .val(cur));
  board_tile_sel u_sel_right (.snap(snap), .idx(idx_right), .val(right));
  board_tile_sel u_sel_below (.snap(snap), .idx(idx_below), .val(below));

  // Neighbours are masked at the right column and bottom row, so nothing wraps.
  assign pair_hit = (cur != '0) &&
                    (((idx[1:0] != 2'd3) && (cur == right)) ||
                     ((idx[3:2] != 2'd3) && (cur == below)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE: if (start) next_state = ST_SCAN;
      ST_SCAN: if (idx == IDX_W'(N_TILES - 1)) next_state = ST_DONE;
      ST_DONE: next_state = ST_IDLE;
      default: next_state = ST_IDLE;
    endcase
  end

  always_comb begin
    busy    = (state == ST_SCAN);
    snap_en = (state == ST_IDLE) && start;
    scan_en = (state == ST_SCAN);
    load_en = (state == ST_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      snap       <= '0;
      idx        <= '0;
      empty_acc  <= '0;
      max_acc    <= '0;
      pair_acc   <= 1'b0;
      tile_valid <= 1'b0;
      tile_idx   <= '0;
      tile_val   <= '0;
    end else begin
      tile_valid <= scan_en;
      if (snap_en) begin
        snap      <= board;
        idx       <= '0;
        empty_acc <= '0;
        max_acc   <= '0;
        pair_acc  <= 1'b0;
      end else if (scan_en) begin
        idx       <= idx + IDX_W'(1);
        empty_acc <= empty_acc + CNT_W'(cur == '0);
        max_acc   <= tile_max(max_acc, cur);
        pair_acc  <= pair_acc | pair_hit;
        tile_idx  <= idx;
        tile_val  <= cur;
      end
    end
  end

  // Result registers only move in DONE, so they stay stable across a scan.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done      <= 1'b0;
      empty_cnt <= '0;
      max_tile  <= '0;
      win       <= 1'b0;
      game_over <= 1'b0;
    end else begin
      done <= load_en;
      if (load_en) begin
        empty_cnt <= empty_acc;
        max_tile  <= max_acc;
        win       <= (int'(max_acc) >= WIN_EXP);
        game_over <= (empty_acc == '0) && !pair_acc;
      end
    end
  end

endmodule

// File: tb/tb_board_scanner.sv
// Directed and randomized bench for board_scanner against a grid-based reference model.
module tb_board_scanner;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [63:0] board;
  logic        busy, done, tile_valid, win, game_over;
  logic [3:0]  tile_idx, tile_val, max_tile;
  logic [4:0]  empty_cnt;

  int checks = 0;
  int errors = 0;
  int prev_empty = 0;
  int prev_max = 0;

  board_scanner #(.WIN_EXP(11)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .board(board),
    .busy(busy), .done(done), .tile_valid(tile_valid),
    .tile_idx(tile_idx), .tile_val(tile_val),
    .empty_cnt(empty_cnt), .max_tile(max_tile),
    .win(win), .game_over(game_over)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int tile_of(input logic [63:0] b, input int k);
    logic [63:0] t;
    t = b >> (4 * (15 - k));
    return int'(t[3:0]);
  endfunction

  // Reference: rebuild a 4x4 grid and apply the game rules directly.
  function automatic void model(input logic [63:0] b, output int e, output int m,
                                output bit go);
    int  g[4][4];
    bit  pair;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        g[r][c] = tile_of(b, r * 4 + c);
    e = 0; m = 0; pair = 0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) begin
        if (g[r][c] == 0) e++;
        if (g[r][c] > m) m = g[r][c];
        if (g[r][c] != 0 && c < 3 && g[r][c] == g[r][c+1]) pair = 1;
        if (g[r][c] != 0 && r < 3 && g[r][c] == g[r+1][c]) pair = 1;
      end
    go = (e == 0) && !pair;
  endfunction

  task automatic do_scan(input logic [63:0] b, input bit disturb);
    int e, m, k, extra;
    bit go, got;
    model(b, e, m, go);
    @(negedge clk); board = b; start = 1'b1;
    @(negedge clk); start = 1'b0;
    chk("busy_after_start", busy, 1);
    got = 0; k = 0;
    while (!got && k < 40) begin
      @(negedge clk); k++;
      if (disturb && k == 5) board = '0;
      if (disturb && k == 6) start = 1'b1;
      if (disturb && k == 7) start = 1'b0;
      if (k <= 16) begin
        chk("tile_valid", tile_valid, 1);
        chk("tile_idx", tile_idx, k - 1);
        chk("tile_val", tile_val, tile_of(b, k - 1));
        chk("busy_scan", busy, (k < 16) ? 1 : 0);
      end
      if (k == 8) begin
        chk("hold_empty", empty_cnt, prev_empty);
        chk("hold_max", max_tile, prev_max);
      end
      if (done) got = 1;
    end
    chk("done_latency", k, 17);
    chk("empty_cnt", empty_cnt, e);
    chk("max_tile", max_tile, m);
    chk("win", win, (m >= 11) ? 1 : 0);
    chk("game_over", game_over, go);
    extra = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done || busy || tile_valid) extra++;
    end
    chk("quiet_after_done", extra, 0);
    prev_empty = e;
    prev_max = m;
  endtask

  initial begin
    logic [63:0] rb;
    int extra;
    rst_n = 1'b0; start = 1'b0; board = '0;
    #2;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_valid", tile_valid, 0);
    chk("rst_empty", empty_cnt, 0);
    chk("rst_max", max_tile, 0);
    chk("rst_win", win, 0);
    chk("rst_go", game_over, 0);
    @(negedge clk); @(negedge clk); rst_n = 1'b1;

    do_scan(64'h0100000000000010, 0);
    do_scan(64'h1212212112122121, 0);
    do_scan(64'h1212212112122122, 0);
    do_scan(64'h00000B0000000000, 0);
    do_scan(64'h0100000000000010, 1);
    do_scan(64'h123456789ABCDEF1, 0);

    // Reset in the middle of a scan.
    @(negedge clk); board = 64'h1212212112122121; start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (8) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_valid", tile_valid, 0);
    chk("abort_empty", empty_cnt, 0);
    chk("abort_max", max_tile, 0);
    chk("abort_win", win, 0);
    chk("abort_go", game_over, 0);
    @(negedge clk); rst_n = 1'b1;
    extra = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done || busy) extra++;
    end
    chk("abort_no_done", extra, 0);
    prev_empty = 0; prev_max = 0;
    do_scan(64'h0, 0);

    for (int n = 0; n < 30; n++) begin
      rb = '0;
      for (int t = 0; t < 16; t++) begin
        rb = rb << 4;
        if (n % 3 == 0) rb[3:0] = 4'($urandom_range(1, 15));
        else if ($urandom_range(0, 3) == 0) rb[3:0] = 4'd0;
        else rb[3:0] = 4'($urandom_range(1, 12));
      end
      do_scan(rb, (n % 7) == 3);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
